// File: rtl/axis_prbs_pkg.sv
// Shared PRBS16 definitions for the stream source and checker, so both sides
// always produce the same sequence.
package axis_prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Taps x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10.
  localparam logic [15:0] PRBS16_POLY  = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] prbs16_next(input logic [15:0] e);
    return {e[14:0], ^(e & PRBS16_POLY)};
  endfunction

endpackage

// File: rtl/prbs16_lfsr.sv
// Fibonacci PRBS16 register with load-to-seed and single-step advance.
// Load wins over advance when both are asserted.
module prbs16_lfsr
  import axis_prbs_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED;
    end else if (advance) begin
      value_d = prbs16_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/axis_prbs_checker.sv
// AXI-Stream sink that checks each accepted beat against a PRBS16 reference
// and reports beat/error counts plus the first mismatch.
module axis_prbs_checker
  import axis_prbs_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter logic [15:0] SEED      = DEFAULT_SEED,
  parameter int unsigned NUM_BEATS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              s_axis_tvaild,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic [31:0]       beat_cnt,
  output logic [15:0]       err_cnt,
  output logic [31:0]       first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam logic [31:0] LAST_IDX = 32'(NUM_BEATS - 1);

  state_e            state_q, state_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       first_err_idx_q, first_err_idx_d;
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;

  logic [15:0] expected;
  logic        run_start;
  logic        accept;
  logic        mismatch;

  assign s_axis_tready = (state_q == ST_RUN) & ~stall;
  assign accept        = s_axis_tvaild & s_axis_tready;
  assign run_start     = start & (state_q != ST_RUN);
  assign mismatch      = accept & (s_axis_tdata != expected);

  prbs16_lfsr #(
    .SEED (SEED)
  ) u_ref (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (run_start),
    .advance (accept),
    .value   (expected)
  );

  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;

    if (run_start) begin
      state_d          = ST_RUN;
      beat_cnt_d       = '0;
      err_cnt_d        = '0;
      first_err_idx_d  = '0;
      first_err_data_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        // Capture keyed on the pre-increment count so only the first error sticks.
        if (err_cnt_q == '0) begin
          first_err_idx_d  = beat_cnt_q;
          first_err_data_d = s_axis_tdata;
        end
      end
      if (beat_cnt_q == LAST_IDX) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      beat_cnt_q       <= '0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
    end
  end

  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done & (err_cnt_q == '0);

endmodule

// File: tb/tb_axis_prbs_checker.sv
// Bench for axis_prbs_checker: a queue-based model of the accepted stream is
// compared against the main instance every cycle; a second instance covers saturation.
module tb_axis_prbs_checker;

  localparam int unsigned NB     = 16;
  localparam int unsigned NB_SAT = 70000;

  logic        clk;
  logic        rst_n;
  logic        start, stall, valid;
  logic [15:0] data;
  logic        tready;
  logic [31:0] beat_cnt, first_err_idx;
  logic [15:0] err_cnt, first_err_data;
  logic        busy, done, pass;

  logic        start_s, valid_s;
  logic [15:0] data_s;
  logic        tready_s;
  logic [31:0] beat_cnt_s, first_err_idx_s;
  logic [15:0] err_cnt_s, first_err_data_s;
  logic        busy_s, done_s, pass_s;

  int n_checks = 0;
  int n_fail   = 0;

  axis_prbs_checker #(
    .DATA_W    (16),
    .SEED      (16'hACE1),
    .NUM_BEATS (NB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stall          (stall),
    .s_axis_tvaild  (valid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (data),
    .beat_cnt       (beat_cnt),
    .err_cnt        (err_cnt),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass)
  );

  axis_prbs_checker #(
    .DATA_W    (16),
    .SEED      (16'hACE1),
    .NUM_BEATS (NB_SAT)
  ) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_s),
    .stall          (1'b0),
    .s_axis_tvaild  (valid_s),
    .s_axis_tready  (tready_s),
    .s_axis_tdata   (data_s),
    .beat_cnt       (beat_cnt_s),
    .err_cnt        (err_cnt_s),
    .first_err_idx  (first_err_idx_s),
    .first_err_data (first_err_data_s),
    .busy           (busy_s),
    .done           (done_s),
    .pass           (pass_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence straight from the polynomial definition.
  logic [15:0] ref_seq [64];
  initial begin
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < 64; i++) begin
      ref_seq[i] = v;
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
  end

  // Model: whether a run is active/finished plus the beats accepted in this run.
  bit          m_run, m_done;
  logic [15:0] rx [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      rx.delete();
    end else if (m_run) begin
      if (valid && !stall) begin
        rx.push_back(data);
        if (rx.size() == NB) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (start) begin
      m_run  = 1'b1;
      m_done = 1'b0;
      rx.delete();
    end
  end

  always @(negedge clk) begin
    int          errs;
    int          fidx;
    logic [15:0] fdat;
    errs = 0;
    fidx = 0;
    fdat = '0;
    foreach (rx[i]) begin
      if (rx[i] !== ref_seq[i]) begin
        if (errs == 0) begin
          fidx = i;
          fdat = rx[i];
        end
        errs++;
      end
    end
    if (errs > 16'hFFFF) errs = 16'hFFFF;
    chk("tready", 32'(tready), 32'(m_run && !stall));
    chk("beat_cnt", beat_cnt, 32'(rx.size()));
    chk("err_cnt", 32'(err_cnt), 32'(errs));
    chk("first_err_idx", first_err_idx, 32'(fidx));
    chk("first_err_data", 32'(first_err_data), 32'(fdat));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_done && errs == 0));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] beats[$], input bit gaps, input bit toggle,
                      output int cycles);
    int k;
    bit acc;
    k      = 0;
    cycles = 0;
    while (k < beats.size() && cycles < 500) begin
      valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      data  = beats[k];
      if (toggle) stall = ~stall;
      #3;
      acc = valid && tready;
      @(posedge clk);
      #2;
      cycles++;
      if (acc) k++;
    end
    valid = 1'b0;
    stall = 1'b0;
    chk("send_complete", 32'(k), 32'(beats.size()));
  endtask

  initial begin
    logic [15:0] q[$];
    int          cyc;
    bit          seen_done;

    rst_n = 1'b0; start = 0; stall = 0; valid = 0; data = '0;
    start_s = 0; valid_s = 0; data_s = '0;
    step();
    step();

    chk("ref_seq0", 32'(ref_seq[0]), 32'h0000ACE1);
    chk("ref_seq1", 32'(ref_seq[1]), 32'h000059C3);
    chk("ref_seq2", 32'(ref_seq[2]), 32'h0000B387);
    chk("ref_seq3", 32'(ref_seq[3]), 32'h0000670F);
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    chk("rst_busy_done", 32'({busy, done, pass}), 32'd0);
    rst_n = 1'b1;
    step();

    // Clean run at full throughput, then valid held past the last beat.
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(ref_seq[i]);
    send(q, 0, 0, cyc);
    chk("clean_cycles", 32'(cyc), 32'(NB));
    valid = 1'b1;
    data  = ref_seq[NB];
    repeat (3) step();
    valid = 1'b0;
    chk("clean_beat_cnt", beat_cnt, 32'd16);
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_tready", 32'(tready), 32'd0);

    // Ignored start while running, single corruption on beat 5.
    pulse_start();
    pulse_start();
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(i == 5 ? ref_seq[i] ^ 16'h0001 : ref_seq[i]);
    send(q, 0, 0, cyc);
    chk("corr_err_cnt", 32'(err_cnt), 32'd1);
    chk("corr_first_idx", first_err_idx, 32'd5);
    chk("corr_first_data", 32'(first_err_data), 32'(16'h4D43 ^ 16'h0001) ^ 32'(16'h4D43 ^ ref_seq[5]));
    chk("corr_pass", 32'(pass), 32'd0);
    chk("corr_done", 32'(done), 32'd1);

    // Backpressure toggling with random valid gaps.
    pulse_start();
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(ref_seq[i]);
    send(q, 1, 1, cyc);
    step();
    chk("bp_beat_cnt", beat_cnt, 32'd16);
    chk("bp_err_cnt", 32'(err_cnt), 32'd0);

    // Dropped beat 3: every following beat is off by one position.
    pulse_start();
    q = {};
    for (int i = 0; i <= NB; i++) if (i != 3) q.push_back(ref_seq[i]);
    send(q, 0, 0, cyc);
    chk("drop_first_idx", first_err_idx, 32'd3);
    chk("drop_err_cnt", 32'(err_cnt), 32'd13);
    chk("drop_first_data", 32'(first_err_data), 32'(ref_seq[4]));

    // Asynchronous reset mid-run, no acceptance until a new start.
    pulse_start();
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(ref_seq[i]);
    send(q, 0, 0, cyc);
    chk("mid_beat_cnt", beat_cnt, 32'd7);
    valid = 1'b1;
    data  = ref_seq[7];
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_tready", 32'(tready), 32'd0);
    chk("async_beat_cnt", beat_cnt, 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    valid = 1'b0;
    chk("post_rst_beat_cnt", beat_cnt, 32'd0);
    pulse_start();
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(ref_seq[i]);
    send(q, 0, 0, cyc);
    chk("rerun_pass", 32'(pass), 32'd1);

    // Saturation on the long instance with all-zero data.
    valid_s = 1'b1;
    data_s  = '0;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    seen_done = 0;
    for (int i = 0; i < NB_SAT + 100 && !seen_done; i++) begin
      step();
      seen_done = done_s;
    end
    chk("sat_done", 32'(done_s), 32'd1);
    chk("sat_err_cnt", 32'(err_cnt_s), 32'h0000FFFF);
    chk("sat_beat_cnt", beat_cnt_s, 32'(NB_SAT));
    chk("sat_first_idx", first_err_idx_s, 32'd0);
    chk("sat_pass", 32'(pass_s), 32'd0);

    start_s = 1'b1;
    step();
    start_s = 1'b0;
    chk("sat_restart_err", 32'(err_cnt_s), 32'd0);
    chk("sat_restart_beats", beat_cnt_s, 32'd0);
    chk("sat_restart_busy", 32'({busy_s, done_s}), 32'b10);
    for (int i = 0; i < 20; i++) begin
      data_s = ref_seq[i];
      step();
    end
    valid_s = 1'b0;
    chk("sat_clean_beats", beat_cnt_s, 32'd20);
    chk("sat_clean_err", 32'(err_cnt_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
